// File: rtl/dct_pkg.sv
// Shared definitions for the DCT row stage.
// Holds the row-stage FSM state encoding, default datapath widths,
// the pixel level-shift constant and the coefficient lane-packing offsets.
package dct_pkg;

    localparam int PIX_W       = 8;    // unsigned input pixel width
    localparam int COEF_W      = 9;    // packed signed coefficient width
    localparam int SHIFT       = 2;    // arithmetic right shift on full-width coefficients
    localparam int LEVEL_SHIFT = 128;  // centres unsigned pixels around zero
    localparam int LANES       = 4;    // coefficients per row word

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CALC    = 2'd1,
        S_PUSH    = 2'd2
    } state_t;

    // Lane 0 (c0) occupies the most significant slot of the packed word,
    // lane 3 (c3) the least significant one.
    function automatic int lane_lsb(input int lane, input int coef_w);
        return (LANES - 1 - lane) * coef_w;
    endfunction

endpackage

// File: rtl/dct4_row_stage_if.sv
// Bundle of the row stage's pixel-input handshake and FIFO write port.
//   pix_valid/pix_in/pix_ready : serial pixel stream, x0 first
//   fifo_full                  : downstream FIFO full flag
//   wr_en/din/out_last         : FIFO write strobe, packed row, block-end marker
// master = pixel source / FIFO side, slave = the row stage.
interface dct4_row_stage_if #(
    parameter int PIX_W  = dct_pkg::PIX_W,
    parameter int COEF_W = dct_pkg::COEF_W
) ();

    logic                  pix_valid;
    logic [PIX_W-1:0]      pix_in;
    logic                  pix_ready;
    logic                  fifo_full;
    logic                  wr_en;
    logic [4*COEF_W-1:0]   din;
    logic                  out_last;

    modport master (
        output pix_valid, pix_in, fifo_full,
        input  pix_ready, wr_en, din, out_last
    );

    modport slave (
        input  pix_valid, pix_in, fifo_full,
        output pix_ready, wr_en, din, out_last
    );

endinterface

// File: rtl/dct4_butterfly.sv
// Combinational 4-point integer DCT on one row of level-shifted samples.
//   x : four signed PIX_W samples, x[0] = x0
//   c : four signed COEF_W coefficients, each the full-width result
//       arithmetically shifted right by SHIFT (floor)
module dct4_butterfly #(
    parameter int PIX_W  = dct_pkg::PIX_W,
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int SHIFT  = dct_pkg::SHIFT
) (
    input  logic signed [PIX_W-1:0]  x [4],
    output logic signed [COEF_W-1:0] c [4]
);

    // Worst case magnitude is 3*2^(PIX_W-1)*2 (y1/y3), so three guard bits suffice.
    localparam int FULL_W = PIX_W + 3;

    logic signed [FULL_W-1:0] e [4];
    logic signed [FULL_W-1:0] y [4];
    logic signed [FULL_W-1:0] s03, d03, s12, d12;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            assign e[gi] = FULL_W'(x[gi]);
        end
    endgenerate

    // Shared butterfly terms.
    assign s03 = e[0] + e[3];
    assign d03 = e[0] - e[3];
    assign s12 = e[1] + e[2];
    assign d12 = e[1] - e[2];

    assign y[0] = s03 + s12;
    assign y[1] = (d03 <<< 1) + d12;
    assign y[2] = s03 - s12;
    assign y[3] = d03 - (d12 <<< 1);

    // After the shift every result fits in COEF_W, so truncation is lossless.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift
            assign c[gi] = COEF_W'(y[gi] >>> SHIFT);
        end
    endgenerate

endmodule

// File: rtl/dct4_row_stage.sv
// Front stage of the 2D DCT: collects four pixels, level-shifts them,
// runs the 4-point row DCT and writes the packed row into the coefficient FIFO.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : pixel handshake in, FIFO write port out (dct4_row_stage_if.slave)
// Row period without backpressure is 6 cycles: 4 accept, 1 calc, 1 push.
module dct4_row_stage
    import dct_pkg::*;
#(
    parameter int PIX_W  = dct_pkg::PIX_W,
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int SHIFT  = dct_pkg::SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    dct4_row_stage_if.slave   bus
);

    localparam int DIN_W = 4 * COEF_W;

    state_t                   state_reg, state_next;
    logic [1:0]               cnt_reg, cnt_next;
    logic [1:0]               row_reg, row_next;
    logic signed [PIX_W-1:0]  samp_reg [4];
    logic signed [PIX_W-1:0]  pix_shifted;
    logic signed [COEF_W-1:0] coef [4];
    logic [DIN_W-1:0]         coef_packed;
    logic [DIN_W-1:0]         din_reg;
    logic                     accept;
    logic                     load_din;

    // Level shift: subtract 128 in PIX_W bits and reinterpret as signed.
    assign pix_shifted = $signed(bus.pix_in - PIX_W'(LEVEL_SHIFT));
    assign accept      = bus.pix_ready & bus.pix_valid;

    // Sample registers: slot cnt_reg captures the pixel on each handshake.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_samp
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    samp_reg[gi] <= '0;
                end else if (accept && (cnt_reg == 2'(gi))) begin
                    samp_reg[gi] <= pix_shifted;
                end
            end
        end
    endgenerate

    dct4_butterfly #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .SHIFT  (SHIFT)
    ) u_butterfly (
        .x (samp_reg),
        .c (coef)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign coef_packed[lane_lsb(gi, COEF_W) +: COEF_W] = coef[gi];
        end
    endgenerate

    // State, counters and output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_COLLECT;
            cnt_reg   <= 2'd0;
            row_reg   <= 2'd0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
            if (load_din) begin
                din_reg <= coef_packed;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        row_next      = row_reg;
        load_din      = 1'b0;
        bus.pix_ready = 1'b0;
        bus.wr_en     = 1'b0;
        unique case (state_reg)
            S_COLLECT: begin
                bus.pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    // 2-bit count wraps to 0 on the fourth sample.
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                load_din   = 1'b1;
                state_next = S_PUSH;
            end
            S_PUSH: begin
                // Write strobe is gated directly by fifo_full so it can never
                // fire into a full FIFO.
                if (!bus.fifo_full) begin
                    bus.wr_en  = 1'b1;
                    row_next   = row_reg + 2'd1;
                    state_next = S_COLLECT;
                end
            end
            default: begin
                state_next = S_COLLECT;
            end
        endcase
    end

    assign bus.din      = din_reg;
    assign bus.out_last = bus.wr_en & (row_reg == 2'd3);

endmodule

// File: tb/tb_dct4_row_stage.sv
module tb_dct4_row_stage;
    import dct_pkg::*;

    localparam int NVEC = 8;

    typedef struct {
        logic [3:0][7:0] pix;
        logic [35:0]     exp_din;
    } vec_t;

    typedef struct packed {
        logic [35:0] din;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct4_row_stage_if bus_if ();

    dct4_row_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   tests  = 0;
    int   fails  = 0;
    int   writes = 0;
    int   tb_row = 0;
    exp_t exp_q[$];
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int floor_div4(input int y);
        if (y >= 0) return y / 4;
        return -((-y + 3) / 4);
    endfunction

    // Reference row DCT straight from the coefficient equations.
    function automatic logic [35:0] model_row(input logic [3:0][7:0] p);
        int x[4];
        int y[4];
        int c;
        logic [35:0] w;
        for (int i = 0; i < 4; i++) x[i] = int'(p[i]) - 128;
        y[0] = x[0] + x[1] + x[2] + x[3];
        y[1] = 2 * (x[0] - x[3]) + (x[1] - x[2]);
        y[2] = x[0] - x[1] - x[2] + x[3];
        y[3] = (x[0] - x[3]) - 2 * (x[1] - x[2]);
        w = '0;
        for (int i = 0; i < 4; i++) begin
            c = floor_div4(y[i]);
            w[(3 - i) * 9 +: 9] = c[8:0];
        end
        return w;
    endfunction

    function automatic logic [3:0][7:0] mk(input logic [7:0] p0, input logic [7:0] p1,
                                           input logic [7:0] p2, input logic [7:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic send_pix(input logic [7:0] p);
        int n;
        n = 0;
        while (bus_if.pix_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: pix_ready stayed %b, expected 1 within 100 cycles", bus_if.pix_ready);
        end
        bus_if.pix_valid = 1'b1;
        bus_if.pix_in    = p;
        @(negedge clk);
    endtask

    task automatic send_row(input logic [3:0][7:0] p, input logic [35:0] exp_din);
        exp_t e;
        e.din  = exp_din;
        e.last = (tb_row == 3);
        exp_q.push_back(e);
        tb_row = (tb_row + 1) % 4;
        for (int i = 0; i < 4; i++) send_pix(p[i]);
        bus_if.pix_valid = 1'b0;
        bus_if.pix_in    = '0;
    endtask

    // Scoreboard: every FIFO write pops one expected row.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1 && bus_if.wr_en === 1'b1) begin
                writes++;
                check("wr_en_while_full", 64'(bus_if.fifo_full), 64'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: din=%h, expected no write", bus_if.din);
                end else begin
                    e = exp_q.pop_front();
                    check("din", 64'(bus_if.din), 64'(e.din));
                    check("out_last", 64'(bus_if.out_last), 64'(e.last));
                    $display("[TB] write %0d din=%h out_last=%b", writes, bus_if.din, bus_if.out_last);
                end
            end
        end
    end

    initial begin
        int w0;
        int n;
        rst              = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_in    = '0;
        bus_if.fifo_full = 1'b0;

        vecs[0].pix = mk(8'd128, 8'd128, 8'd128, 8'd128); vecs[0].exp_din = 36'h000000000;
        vecs[1].pix = mk(8'd255, 8'd255, 8'd255, 8'd255); vecs[1].exp_din = 36'h3F8000000;
        vecs[2].pix = mk(8'd0,   8'd0,   8'd255, 8'd255); vecs[2].exp_din = {9'h1FF, 9'h140, 9'h000, 9'h03F};
        vecs[3].pix = mk(8'd0,   8'd0,   8'd0,   8'd0);   vecs[3].exp_din = {9'h180, 9'h000, 9'h000, 9'h000};
        vecs[4].pix = mk(8'd255, 8'd0,   8'd0,   8'd255); vecs[4].exp_din = {9'h1FF, 9'h000, 9'h07F, 9'h000};
        for (int i = 5; i < NVEC; i++) begin
            vecs[i].pix = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            vecs[i].exp_din = model_row(vecs[i].pix);
        end

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_pix_ready", 64'(bus_if.pix_ready), 64'd1);
        check("rst_wr_en", 64'(bus_if.wr_en), 64'd0);
        check("rst_out_last", 64'(bus_if.out_last), 64'd0);
        check("rst_din", 64'(bus_if.din), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: 8 rows = two 4x4 blocks, out_last on rows 4 and 8.
        for (int i = 0; i < NVEC; i++) send_row(vecs[i].pix, vecs[i].exp_din);

        // Latency: x3 accepted at edge n -> calc cycle, then wr_en in cycle n+2.
        send_row(mk(8'd128, 8'd128, 8'd128, 8'd128), 36'h000000000);
        #1;
        check("lat_calc_wr_en", 64'(bus_if.wr_en), 64'd0);
        check("lat_calc_ready", 64'(bus_if.pix_ready), 64'd0);
        @(negedge clk);
        #1;
        check("lat_push_wr_en", 64'(bus_if.wr_en), 64'd1);
        @(negedge clk);
        #1;
        check("lat_after_ready", 64'(bus_if.pix_ready), 64'd1);

        // Backpressure: hold fifo_full for 5 cycles in S_PUSH.
        @(negedge clk);
        bus_if.fifo_full = 1'b1;
        send_row(mk(8'd0, 8'd0, 8'd255, 8'd255), {9'h1FF, 9'h140, 9'h000, 9'h03F});
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_wr_en", 64'(bus_if.wr_en), 64'd0);
            check("bp_ready", 64'(bus_if.pix_ready), 64'd0);
            check("bp_din", 64'(bus_if.din), 64'({9'h1FF, 9'h140, 9'h000, 9'h03F}));
            @(negedge clk);
        end
        w0 = writes;
        bus_if.fifo_full = 1'b0;
        #1;
        check("bp_release_wr_en", 64'(bus_if.wr_en), 64'd1);
        @(negedge clk);
        #2;
        check("bp_after_wr_en", 64'(bus_if.wr_en), 64'd0);
        check("bp_after_ready", 64'(bus_if.pix_ready), 64'd1);
        check("bp_write_count", 64'(writes - w0), 64'd1);

        // Reset mid-row: two contaminating samples, then reset.
        @(negedge clk);
        send_pix(8'd0);
        send_pix(8'd0);
        bus_if.pix_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_pix_ready", 64'(bus_if.pix_ready), 64'd1);
        check("mid_rst_wr_en", 64'(bus_if.wr_en), 64'd0);
        check("mid_rst_out_last", 64'(bus_if.out_last), 64'd0);
        check("mid_rst_din", 64'(bus_if.din), 64'd0);
        exp_q.delete();
        tb_row = 0;
        @(negedge clk);
        rst = 1'b1;
        // Row counter restarts at 0: out_last only on the 4th row after reset.
        for (int r = 0; r < 4; r++) send_row(mk(8'd255, 8'd255, 8'd255, 8'd255), 36'h3F8000000);

        // Drain outstanding writes.
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d rows still pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
